stopwatch_ctrl: RTL and testbench

- Controller that sequences a cascaded chain of BCD digit counters (mod-10 / mod-6 / mod-10 / mod-6) as an MM:SS stopwatch.
- Owns the run/pause/clear state machine, the clock prescaler that generates the count tick, and the per-digit enables and carries.
- Sits between debounced single-cycle button pulses and the display driver.

---
 rtl/stopwatch_ctrl_if.sv | 35 +++
 rtl/stopwatch_ctrl.sv | 157 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Bundles the button pulses and the MM:SS display outputs of stopwatch_ctrl.
// STOPWATCH_LAP_EN adds the lap pulse and the lap_held indicator.
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_clr;
  logic [3:0] sec_lo;
  logic [3:0] sec_hi;
  logic [3:0] min_lo;
  logic [3:0] min_hi;
  logic       running;
  logic       full;
  logic       co;
`ifdef STOPWATCH_LAP_EN
  logic       lap;
  logic       lap_held;

  modport master (
    output btn_ss, btn_clr, lap,
    input  sec_lo, sec_hi, min_lo, min_hi, running, full, co, lap_held
  );
  modport slave (
    input  btn_ss, btn_clr, lap,
    output sec_lo, sec_hi, min_lo, min_hi, running, full, co, lap_held
  );
`else
  modport master (
    output btn_ss, btn_clr,
    input  sec_lo, sec_hi, min_lo, min_hi, running, full, co
  );
  modport slave (
    input  btn_ss, btn_clr,
    output sec_lo, sec_hi, min_lo, min_hi, running, full, co
  );
`endif
endinterface

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: run/pause/clear FSM, tick prescaler and BCD digit cascade.
// Optional lap-hold display is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100,
  parameter int PRE_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_secLo;
  logic [3:0]       r_secHi;
  logic [3:0]       r_minLo;
  logic [3:0]       r_minHi;
  logic             r_running;
  logic             r_full;
  logic             r_co;

  logic w_tick;
  logic w_secAt59;
  logic w_atMax;
  logic w_advance;

  assign w_tick    = (r_state == ST_RUN) && (r_pre == PRE_W'(TICK_DIV - 1));
  assign w_secAt59 = (r_secHi == 4'd5) && (r_secLo == 4'd9);
  assign w_atMax   = w_secAt59 && (r_minHi == 4'd5) && (r_minLo == 4'd9);
  // A tick at 59:59 saturates instead of wrapping the display.
  assign w_advance = w_tick && !w_atMax;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.btn_clr) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (bus.btn_ss) w_next = ST_RUN;
        ST_RUN: begin
          if (bus.btn_ss) begin
            w_next = ST_PAUSE;
          end else if (w_tick && w_atMax) begin
            w_next = ST_FULL;
          end
        end
        ST_PAUSE: if (bus.btn_ss) w_next = ST_RUN;
        ST_FULL:  w_next = ST_FULL;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // A pause press freezes the partial period so resume finishes it.
  always_ff @(posedge clk) begin
    if (rst || bus.btn_clr) begin
      r_pre <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_tick) begin
        r_pre <= '0;
      end else if (!bus.btn_ss) begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.btn_clr) begin
      r_secLo <= 4'd0;
      r_secHi <= 4'd0;
      r_minLo <= 4'd0;
      r_minHi <= 4'd0;
    end else if (w_advance) begin
      r_secLo <= (r_secLo == 4'd9) ? 4'd0 : r_secLo + 4'd1;
      if (r_secLo == 4'd9) begin
        r_secHi <= (r_secHi == 4'd5) ? 4'd0 : r_secHi + 4'd1;
      end
      if (w_secAt59) begin
        r_minLo <= (r_minLo == 4'd9) ? 4'd0 : r_minLo + 4'd1;
      end
      if (w_secAt59 && (r_minLo == 4'd9)) begin
        r_minHi <= r_minHi + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_running <= 1'b0;
      r_full    <= 1'b0;
      r_co      <= 1'b0;
    end else begin
      r_running <= (w_next == ST_RUN);
      r_full    <= (w_next == ST_FULL);
      r_co      <= !bus.btn_clr && w_advance && w_secAt59;
    end
  end

  assign bus.running = r_running;
  assign bus.full    = r_full;
  assign bus.co      = r_co;

`ifdef STOPWATCH_LAP_EN
  logic       r_lapHeld;
  logic [3:0] r_lapSecLo;
  logic [3:0] r_lapSecHi;
  logic [3:0] r_lapMinLo;
  logic [3:0] r_lapMinHi;

  // Lap presses toggle a frozen snapshot; counting carries on underneath.
  always_ff @(posedge clk) begin
    if (rst || bus.btn_clr) begin
      r_lapHeld  <= 1'b0;
      r_lapSecLo <= 4'd0;
      r_lapSecHi <= 4'd0;
      r_lapMinLo <= 4'd0;
      r_lapMinHi <= 4'd0;
    end else if (bus.lap && (r_state == ST_RUN)) begin
      r_lapHeld <= !r_lapHeld;
      if (!r_lapHeld) begin
        r_lapSecLo <= r_secLo;
        r_lapSecHi <= r_secHi;
        r_lapMinLo <= r_minLo;
        r_lapMinHi <= r_minHi;
      end
    end
  end

  assign bus.lap_held = r_lapHeld;
  assign bus.sec_lo   = r_lapHeld ? r_lapSecLo : r_secLo;
  assign bus.sec_hi   = r_lapHeld ? r_lapSecHi : r_secHi;
  assign bus.min_lo   = r_lapHeld ? r_lapMinLo : r_minLo;
  assign bus.min_hi   = r_lapHeld ? r_lapMinHi : r_minHi;
`else
  assign bus.sec_lo = r_secLo;
  assign bus.sec_hi = r_secHi;
  assign bus.min_lo = r_minLo;
  assign bus.min_hi = r_minHi;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4, using an elapsed-seconds
// reference model plus fixed expectations from the test plan.
module tb_stopwatch_ctrl;

  localparam int TD      = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_FULL  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stopwatch_ctrl_if swIf();

  stopwatch_ctrl #(.TICK_DIV(TD), .PRE_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (swIf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: total elapsed seconds, cycles into the current second, mode, co pulse.
  int mSecs = 0;
  int mPre  = 0;
  int mMode = M_IDLE;
  int mCo   = 0;

  task automatic modelStep(input logic ss, input logic clr, input logic rs);
    mCo = 0;
    if (rs || clr) begin
      mSecs = 0;
      mPre  = 0;
      mMode = M_IDLE;
    end else begin
      case (mMode)
        M_IDLE:  if (ss) mMode = M_RUN;
        M_RUN: begin
          if (mPre == TD - 1) begin
            mPre = 0;
            if (mSecs == 3599) begin
              mMode = ss ? M_PAUSE : M_FULL;
            end else begin
              if (mSecs % 60 == 59) mCo = 1;
              mSecs++;
              if (ss) mMode = M_PAUSE;
            end
          end else if (ss) begin
            mMode = M_PAUSE;
          end else begin
            mPre++;
          end
        end
        M_PAUSE: if (ss) mMode = M_RUN;
        default: ;
      endcase
    end
  endtask

  function automatic logic [18:0] expVec();
    return {4'(mSecs / 600), 4'((mSecs / 60) % 10), 4'((mSecs % 60) / 10), 4'(mSecs % 10),
            mMode == M_RUN, mMode == M_FULL, mCo != 0};
  endfunction

  function automatic logic [18:0] actVec();
    return {swIf.min_hi, swIf.min_lo, swIf.sec_hi, swIf.sec_lo,
            swIf.running, swIf.full, swIf.co};
  endfunction

  task automatic cycle(input logic ss, input logic clr, input logic rs);
    swIf.btn_ss  = ss;
    swIf.btn_clr = clr;
    rst          = rs;
    @(posedge clk);
    modelStep(ss, clr, rs);
    #1;
    swIf.btn_ss  = 1'b0;
    swIf.btn_clr = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic test_reset();
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0);
      checks++;
      if (actVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL reset_idle cyc=%0d got=%h want=%h", i, actVec(), expVec());
      end
    end
    checks++;
    if (actVec() !== 19'h0) begin
      errors++;
      $display("[TB] FAIL reset_const got=%h want=%h", actVec(), 19'h0);
    end
  endtask

  task automatic test_start();
    cycle(1, 0, 0);
    for (int i = 0; i < 48; i++) begin
      cycle(0, 0, 0);
      checks++;
      if (actVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL start_run cyc=%0d got=%h want=%h", i, actVec(), expVec());
      end
    end
    checks++;
    if ({swIf.sec_hi, swIf.sec_lo, swIf.running} !== {4'd1, 4'd2, 1'b1}) begin
      errors++;
      $display("[TB] FAIL start_12ticks got=%h%h run=%b want=12 run=1",
               swIf.sec_hi, swIf.sec_lo, swIf.running);
    end
  endtask

  task automatic test_pause_resume();
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < TD + 2; i++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0);
      checks++;
      if ({swIf.sec_lo, swIf.running} !== {4'd1, 1'b0} || actVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL pause_hold cyc=%0d got=%h want=%h", i, actVec(), expVec());
      end
    end
    cycle(1, 0, 0);
    checks++;
    if ({swIf.sec_lo, swIf.running} !== {4'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL resume_entry sec_lo=%0d run=%b want sec_lo=1 run=1", swIf.sec_lo, swIf.running);
    end
    cycle(0, 0, 0);
    checks++;
    if (swIf.sec_lo !== 4'd1) begin
      errors++;
      $display("[TB] FAIL resume_early sec_lo=%0d want=1", swIf.sec_lo);
    end
    cycle(0, 0, 0);
    checks++;
    if (swIf.sec_lo !== 4'd2) begin
      errors++;
      $display("[TB] FAIL resume_tick sec_lo=%0d want=2", swIf.sec_lo);
    end
  endtask

  int coSeen = 0;

  task automatic test_rollover();
    int budget;
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    budget = 0;
    coSeen = 0;
    while (mSecs < 60 && budget < 400) begin
      cycle(0, 0, 0);
      budget++;
      if (swIf.co === 1'b1) coSeen++;
      checks++;
      if (actVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL rollover_run cyc=%0d got=%h want=%h", budget, actVec(), expVec());
      end
    end
    checks++;
    if ({swIf.min_hi, swIf.min_lo, swIf.sec_hi, swIf.sec_lo, swIf.co} !== {16'h0100, 1'b1} ||
        coSeen != 1) begin
      errors++;
      $display("[TB] FAIL rollover_0100 got=%h co=%b pulses=%0d want=0100 co=1 pulses=1",
               {swIf.min_hi, swIf.min_lo, swIf.sec_hi, swIf.sec_lo}, swIf.co, coSeen);
    end
    cycle(0, 0, 0);
    checks++;
    if (swIf.co !== 1'b0) begin
      errors++;
      $display("[TB] FAIL co_width co=%b want=0", swIf.co);
    end
  endtask

  task automatic test_saturation();
    int budget;
    budget = 0;
    coSeen = 0;
    while (mMode != M_FULL && budget < 16000) begin
      cycle(0, 0, 0);
      budget++;
      if (swIf.co === 1'b1) coSeen++;
      checks++;
      if (actVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL sat_run cyc=%0d got=%h want=%h", budget, actVec(), expVec());
      end
    end
    checks++;
    if (actVec() !== {16'h5959, 1'b0, 1'b1, 1'b0} || coSeen != 58) begin
      errors++;
      $display("[TB] FAIL sat_entry got=%h pulses=%0d want=%h pulses=58",
               actVec(), coSeen, {16'h5959, 3'b010});
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      for (int j = 0; j < 5; j++) cycle(0, 0, 0);
      checks++;
      if (actVec() !== {16'h5959, 3'b010}) begin
        errors++;
        $display("[TB] FAIL sat_ss_ignored got=%h want=%h", actVec(), {16'h5959, 3'b010});
      end
    end
    cycle(0, 1, 0);
    checks++;
    if (actVec() !== 19'h0) begin
      errors++;
      $display("[TB] FAIL sat_clear got=%h want=0", actVec());
    end
  endtask

  task automatic test_priority();
    cycle(1, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0);
    cycle(1, 1, 0);
    checks++;
    if (actVec() !== 19'h0) begin
      errors++;
      $display("[TB] FAIL clr_beats_ss got=%h want=0", actVec());
    end
    cycle(1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    cycle(0, 0, 1);
    checks++;
    if (actVec() !== 19'h0) begin
      errors++;
      $display("[TB] FAIL mid_run_reset got=%h want=0", actVec());
    end
    cycle(0, 0, 0);
    checks++;
    if (actVec() !== 19'h0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got=%h want=0", actVec());
    end
  endtask

  task automatic test_random();
    logic ss, clr, rs;
    cycle(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      ss  = ($urandom_range(15) == 0);
      clr = ($urandom_range(127) == 0);
      rs  = ($urandom_range(511) == 0);
      cycle(ss, clr, rs);
      checks++;
      if (actVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL random cyc=%0d ss=%b clr=%b rst=%b got=%h want=%h",
                 i, ss, clr, rs, actVec(), expVec());
      end
    end
  endtask

  initial begin
    swIf.btn_ss  = 1'b0;
    swIf.btn_clr = 1'b0;
`ifdef STOPWATCH_LAP_EN
    swIf.lap     = 1'b0;
`endif
    #1;
    test_reset();
    test_start();
    test_pause_resume();
    test_rollover();
    test_saturation();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
